// File: rtl/jtexterm_palrd.sv
// Palette reader: fetches a two-byte palette entry from a registered-read RAM
// and presents registered 5-bit RGB plus re-timed blanking 3 clk after pxl_cen.
module jtexterm_palrd #(
  parameter int PAL_AW      = 10,
  parameter bit BLANK_BLACK = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pxl_cen,
  input  logic              LHBL,
  input  logic              LVBL,
  input  logic [PAL_AW-2:0] pxl_idx,
  output logic [PAL_AW-1:0] pal_addr,
  input  logic [7:0]        pal_dout,
  output logic [4:0]        red,
  output logic [4:0]        green,
  output logic [4:0]        blue,
  output logic              LHBL_dly,
  output logic              LVBL_dly,
  output logic              overrun
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2,
    CAT  = 2'd3
  } state_t;

  state_t            state_r, next_state_s;
  logic [PAL_AW-2:0] idx_r;
  logic              lhbl_r, lvbl_r;
  logic [6:0]        hi_r;
  logic [14:0]       rgb_s;

  // Entry layout: high byte {x, R[4:0], G[4:3]}, low byte {G[2:0], B[4:0]}
  function automatic logic [14:0] unpack_rgb(input logic [6:0] hi_byte, input logic [7:0] lo_byte);
    return {hi_byte[6:2], hi_byte[1:0], lo_byte[7:5], lo_byte[4:0]};
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= next_state_s;
  end

  // Next-state logic: one fetch takes four edges, then back to IDLE
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (pxl_cen) next_state_s = HI;
        else         next_state_s = IDLE;
      end
      HI:      next_state_s = LO;
      LO:      next_state_s = CAT;
      CAT:     next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Colour assembly, forced black on blanked pixels when enabled
  always_comb begin
    rgb_s = unpack_rgb(hi_r, pal_dout);
    if (BLANK_BLACK && !(lhbl_r && lvbl_r)) rgb_s = 15'd0;
    else                                    rgb_s = unpack_rgb(hi_r, pal_dout);
  end

  // Datapath: address sequencing, byte capture, output load, overrun flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pal_addr <= '0;
      idx_r    <= '0;
      lhbl_r   <= 1'b0;
      lvbl_r   <= 1'b0;
      hi_r     <= 7'd0;
      red      <= 5'd0;
      green    <= 5'd0;
      blue     <= 5'd0;
      LHBL_dly <= 1'b0;
      LVBL_dly <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (pxl_cen && state_r != IDLE) overrun <= 1'b1;
      case (state_r)
        IDLE: begin
          if (pxl_cen) begin
            idx_r    <= pxl_idx;
            lhbl_r   <= LHBL;
            lvbl_r   <= LVBL;
            pal_addr <= {pxl_idx, 1'b0};
          end
        end
        HI:  pal_addr <= {idx_r, 1'b1};
        // RAM output now holds the high byte requested two edges ago
        LO:  hi_r <= pal_dout[6:0];
        CAT: begin
          {red, green, blue} <= rgb_s;
          LHBL_dly           <= lhbl_r;
          LVBL_dly           <= lvbl_r;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jtexterm_palrd.sv
// Scoreboard bench for jtexterm_palrd: two instances (blank-black on/off) share
// one palette RAM; expected events are queued by the driver and retired by a monitor.
module tb_jtexterm_palrd;
  logic       clk = 1'b0;
  logic       rst_n, pxl_cen, LHBL, LVBL;
  logic [8:0] pxl_idx;
  logic [9:0] addr_bb, addr_pt;
  logic [7:0] dout_bb, dout_pt;
  logic [4:0] r_bb, g_bb, b_bb, r_pt, g_pt, b_pt;
  logic       hd_bb, vd_bb, ov_bb, hd_pt, vd_pt, ov_pt;
  logic [7:0] mem [0:1023];
  int         edge_cnt = 0;
  int         checks = 0;
  int         errors = 0;
  int         next_free = 0;

  localparam int K_RST = 0, K_ADDR = 1, K_COL = 2, K_OVR = 3;
  typedef struct {
    int          due;
    int          kind;
    logic [9:0]  addr;
    logic [14:0] bb;
    logic [14:0] pt;
    bit          hb;
    bit          vb;
  } ev_t;
  ev_t sb[$];

  logic [9:0]  exp_addr;
  logic [14:0] exp_bb, exp_pt;
  logic        exp_hd, exp_vd, exp_ov;
  bit          chk_en = 1'b0;

  jtexterm_palrd #(.PAL_AW(10), .BLANK_BLACK(1'b1)) dut_bb (
    .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
    .pxl_idx(pxl_idx), .pal_addr(addr_bb), .pal_dout(dout_bb),
    .red(r_bb), .green(g_bb), .blue(b_bb),
    .LHBL_dly(hd_bb), .LVBL_dly(vd_bb), .overrun(ov_bb));

  jtexterm_palrd #(.PAL_AW(10), .BLANK_BLACK(1'b0)) dut_pt (
    .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
    .pxl_idx(pxl_idx), .pal_addr(addr_pt), .pal_dout(dout_pt),
    .red(r_pt), .green(g_pt), .blue(b_pt),
    .LHBL_dly(hd_pt), .LVBL_dly(vd_pt), .overrun(ov_pt));

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;
  always @(posedge clk) begin
    dout_bb <= mem[addr_bb];
    dout_pt <= mem[addr_pt];
  end

  function automatic logic [14:0] colour(input int hi, input int lo);
    int r, g, b;
    r = (hi / 4) % 32;
    g = (hi % 4) * 8 + lo / 32;
    b = lo % 32;
    return 15'(r * 1024 + g * 32 + b);
  endfunction

  function automatic void push_ev(input int due, input int kind, input int addr,
                                  input logic [14:0] bb, input logic [14:0] pt,
                                  input bit hb, input bit vb);
    ev_t ev;
    ev.due = due; ev.kind = kind; ev.addr = 10'(addr);
    ev.bb = bb; ev.pt = pt; ev.hb = hb; ev.vb = vb;
    sb.push_back(ev);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_cnt, act, exp);
    end
  endtask

  // Drive one clock of stimulus and record what the model expects from it
  task automatic cyc(input bit cen, input int idx, input bit hb, input bit vb, input bit rn);
    int          e, hi, lo;
    ev_t         keep[$];
    logic [14:0] full;
    e = edge_cnt + 1;
    rst_n = rn; pxl_cen = cen; pxl_idx = 9'(idx); LHBL = hb; LVBL = vb;
    if (!rn) begin
      foreach (sb[i]) if (sb[i].due < e) keep.push_back(sb[i]);
      sb = keep;
      push_ev(e, K_RST, 0, 15'd0, 15'd0, 1'b0, 1'b0);
      next_free = e + 1;
    end else if (cen) begin
      if (e >= next_free) begin
        next_free = e + 4;
        hi = int'(mem[idx * 2]);
        lo = int'(mem[idx * 2 + 1]);
        full = colour(hi, lo);
        push_ev(e, K_ADDR, idx * 2, 15'd0, 15'd0, 1'b0, 1'b0);
        push_ev(e + 1, K_ADDR, idx * 2 + 1, 15'd0, 15'd0, 1'b0, 1'b0);
        push_ev(e + 3, K_COL, 0, (hb && vb) ? full : 15'd0, full, hb, vb);
      end else begin
        push_ev(e, K_OVR, 0, 15'd0, 15'd0, 1'b0, 1'b0);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b1, 1'b1, 1'b1);
  endtask

  // Monitor: retire due events, then compare every output of both instances
  always @(negedge clk) begin
    int i;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].due <= edge_cnt) begin
        case (sb[i].kind)
          K_RST: begin
            exp_addr = 10'd0; exp_bb = 15'd0; exp_pt = 15'd0;
            exp_hd = 1'b0; exp_vd = 1'b0; exp_ov = 1'b0; chk_en = 1'b1;
          end
          K_ADDR: exp_addr = sb[i].addr;
          K_COL: begin
            exp_bb = sb[i].bb; exp_pt = sb[i].pt;
            exp_hd = sb[i].hb; exp_vd = sb[i].vb;
          end
          default: exp_ov = 1'b1;
        endcase
        sb.delete(i);
      end else begin
        i++;
      end
    end
    if (chk_en) begin
      check("pal_addr_bb", 32'(addr_bb), 32'(exp_addr));
      check("pal_addr_pt", 32'(addr_pt), 32'(exp_addr));
      check("rgb_bb", 32'({r_bb, g_bb, b_bb}), 32'(exp_bb));
      check("rgb_pt", 32'({r_pt, g_pt, b_pt}), 32'(exp_pt));
      check("LHBL_dly_bb", 32'(hd_bb), 32'(exp_hd));
      check("LVBL_dly_bb", 32'(vd_bb), 32'(exp_vd));
      check("LHBL_dly_pt", 32'(hd_pt), 32'(exp_hd));
      check("LVBL_dly_pt", 32'(vd_pt), 32'(exp_vd));
      check("overrun_bb", 32'(ov_bb), 32'(exp_ov));
      check("overrun_pt", 32'(ov_pt), 32'(exp_ov));
    end
  end

  initial begin
    for (int a = 0; a < 1024; a++) mem[a] = 8'($urandom_range(0, 255));
    cyc(1'b1, 3, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 0, 1'b1, 1'b1, 1'b0);
    idle(2);
    // basic fetch, green split, blanking
    mem[10'h0AA] = 8'h7C; mem[10'h0AB] = 8'h1F;
    cyc(1'b1, 9'h055, 1'b1, 1'b1, 1'b1); idle(4);
    mem[10'h020] = 8'h03; mem[10'h021] = 8'hE0;
    cyc(1'b1, 9'h010, 1'b1, 1'b1, 1'b1); idle(4);
    mem[10'h040] = 8'h7F; mem[10'h041] = 8'hFF;
    cyc(1'b1, 9'h020, 1'b0, 1'b1, 1'b1); idle(4);
    cyc(1'b1, 9'h020, 1'b1, 1'b0, 1'b1); idle(4);
    // maximum index addresses the last two bytes
    cyc(1'b1, 9'h1FF, 1'b1, 1'b1, 1'b1); idle(4);
    // back-to-back every 4 clk over 16 indices
    for (int k = 0; k < 16; k++) begin
      cyc(1'b1, 9'h100 + k * 7, 1'b1, 1'b1, 1'b1);
      idle(3);
    end
    idle(2);
    // overrun: second pulse two edges after the first
    cyc(1'b1, 9'h033, 1'b1, 1'b1, 1'b1);
    idle(1);
    cyc(1'b1, 9'h0F0, 1'b1, 1'b1, 1'b1);
    idle(6);
    // reset mid-fetch, then a clean fetch
    cyc(1'b1, 9'h077, 1'b1, 1'b1, 1'b1);
    idle(1);
    cyc(1'b0, 0, 1'b1, 1'b1, 1'b0);
    idle(3);
    cyc(1'b1, 9'h078, 1'b1, 1'b1, 1'b1); idle(4);
    // randomized traffic including overruns and resets
    for (int k = 0; k < 500; k++) begin
      cyc($urandom_range(0, 2) == 0, int'($urandom_range(0, 511)),
          $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 59) != 0);
    end
    idle(6);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
